// File: rtl/gcd_if.sv
// Request/response val-rdy bundle for the GCD engine.
// The master side issues operand pairs and consumes results; the slave side is the engine.
`timescale 1ns/1ps
interface gcd_if #(
  parameter int unsigned W = 16
) ();
  logic [2*W-1:0] req_msg;
  logic           req_val;
  logic           req_rdy;
  logic [W-1:0]   resp_msg;
  logic           resp_val;
  logic           resp_rdy;

  modport master (
    output req_msg, req_val, resp_rdy,
    input  req_rdy, resp_msg, resp_val
  );

  modport slave (
    input  req_msg, req_val, resp_rdy,
    output req_rdy, resp_msg, resp_val
  );
endinterface

// File: rtl/gcd_unit.sv
// Iterative subtraction-based Euclid GCD, one step per cycle, one transaction in flight.
// Optional supply ports for gate-level netlists are enabled with GCD_POWER_PINS_EN.
`timescale 1ns/1ps
module gcd_unit #(
  parameter int unsigned W = 16
) (
  input  logic  clk,
  input  logic  reset,
  gcd_if.slave  bus
`ifdef GCD_POWER_PINS_EN
  ,
  inout  supply1 VDD,
  inout  supply0 VSS
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           req_rdy_q;
  logic           resp_val_q;

  logic           a_lt_b;
  logic [W-1:0]   diff_d;

  assign a_lt_b = a_q < b_q;
  assign diff_d = a_q - b_q;

  // NOTE: reset is sampled on the clock edge only (synchronous), and every
  // register here is state, so all updates use non-blocking assignments;
  // that is also what makes the A/B swap below read the old values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_val && req_rdy_q) begin
            a_q       <= bus.req_msg[2*W-1:W];
            b_q       <= bus.req_msg[W-1:0];
            req_rdy_q <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (a_lt_b) begin
            a_q <= b_q;
            b_q <= a_q;
          end else if (b_q != '0) begin
            a_q <= diff_d;
          end else begin
            resp_val_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_rdy) begin
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          req_rdy_q  <= 1'b1;
          resp_val_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after its first edge.
  assign bus.req_rdy  = req_rdy_q & reset;
  assign bus.resp_val = resp_val_q & reset;
  assign bus.resp_msg = reset ? a_q : '0;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed vectors with literal results plus a
// queue-based reference that checks handshake and result ordering every cycle.
`timescale 1ns/1ps
module tb_gcd_unit;

  localparam int unsigned W = 16;

  logic clk;
  logic reset;
  logic req_en;

  int checks;
  int errors;
  int n_resp;
  logic [W-1:0] exp_q[$];

  gcd_if #(.W(W)) bus ();

`ifdef GCD_POWER_PINS_EN
  supply1 vdd;
  supply0 vss;
`endif

  gcd_unit #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef GCD_POWER_PINS_EN
    ,
    .VDD   (vdd),
    .VSS   (vss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req_val is tied to req_rdy whenever the bench wants to issue.
  assign bus.req_val = bus.req_rdy & req_en;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: modulo-based Euclid, independent of how the hardware iterates.
  function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Compare process: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      check("rst_req_rdy", {31'd0, bus.req_rdy}, 32'd0);
      check("rst_resp_val", {31'd0, bus.resp_val}, 32'd0);
      check("rst_resp_msg", {16'd0, bus.resp_msg}, 32'd0);
    end else begin
      check("req_rdy_vs_inflight", {31'd0, bus.req_rdy}, {31'd0, (exp_q.size() == 0)});
      if (bus.resp_val) begin
        check("resp_has_request", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          check("resp_msg_model", {16'd0, bus.resp_msg}, {16'd0, exp_q[0]});
          if (bus.resp_rdy) begin
            void'(exp_q.pop_front());
            n_resp++;
          end
        end
      end
      if (bus.req_val && bus.req_rdy)
        exp_q.push_back(gcd_model(bus.req_msg[2*W-1:W], bus.req_msg[W-1:0]));
    end
  end

  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_accept"}, {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits for resp_val and checks the literal result.
  task automatic run_req(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int limit, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    bus.req_msg = {a, b};
    req_en = 1'b1;
    wait_accept(name);
    req_en = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.resp_val) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check({name, "_resp_seen"}, {31'd0, got}, 32'd1);
    check({name, "_result"}, {16'd0, bus.resp_msg}, {16'd0, exp});
    if (bus.resp_rdy) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int base;
    logic [W-1:0] va;
    logic [W-1:0] vb;

    checks      = 0;
    errors      = 0;
    n_resp      = 0;
    reset       = 1'b0;
    req_en      = 1'b0;
    bus.req_msg = '0;
    bus.resp_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("idle_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
    check("idle_resp_val", {31'd0, bus.resp_val}, 32'd0);
    @(posedge clk);
    #1;

    run_req("g27_15", 16'd27, 16'd15, 16'd3, 200, lat);
    run_req("g15_27", 16'd15, 16'd27, 16'd3, 200, lat);
    run_req("g0_7", 16'd0, 16'd7, 16'd7, 200, lat);
    run_req("g7_0", 16'd7, 16'd0, 16'd7, 200, lat);
    check("g7_0_latency", lat, 32'd2);
    run_req("g0_0", 16'd0, 16'd0, 16'd0, 200, lat);
    run_req("gffff_ffff", 16'hFFFF, 16'hFFFF, 16'hFFFF, 200, lat);
    run_req("gffff_1", 16'hFFFF, 16'd1, 16'd1, 70000, lat);

    // Backpressure: result must hold while the consumer stalls.
    bus.resp_rdy = 1'b0;
    run_req("bp48_18", 16'd48, 16'd18, 16'd6, 200, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_resp_val", {31'd0, bus.resp_val}, 32'd1);
      check("bp_resp_msg", {16'd0, bus.resp_msg}, 32'd6);
      check("bp_req_rdy", {31'd0, bus.req_rdy}, 32'd0);
    end
    base = n_resp;
    @(posedge clk);
    #1 bus.resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_val", {31'd0, bus.resp_val}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_val", {31'd0, bus.resp_val}, 32'd0);
    check("bp_after_rdy", {31'd0, bus.req_rdy}, 32'd1);
    check("bp_one_handshake", n_resp - base, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a long calculation abandons it.
    bus.req_msg = {16'd1000, 16'd3};
    req_en = 1'b1;
    wait_accept("rst_mid");
    req_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_rdy", {31'd0, bus.req_rdy}, 32'd0);
    check("rst_mid_val", {31'd0, bus.resp_val}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_rel_val", {31'd0, bus.resp_val}, 32'd0);
    check("rst_rel_rdy", {31'd0, bus.req_rdy}, 32'd1);
    @(posedge clk);
    #1;
    base = n_resp;
    run_req("g12_8", 16'd12, 16'd8, 16'd4, 200, lat);
    check("rst_no_stale", n_resp - base, 32'd1);

    // Back-to-back stream with req_val tied to req_rdy.
    base = n_resp;
    req_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      va = W'($urandom_range(0, 63));
      vb = W'($urandom_range(0, 63));
      bus.req_msg = {va, vb};
      wait_accept("stream");
    end
    req_en = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("stream_drained", exp_q.size(), 32'd0);
    check("stream_count", n_resp - base, 32'd100);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
